// File: rtl/sdram_probe_pkg.sv
// sdram_probe_pkg: shared states, probe-step ROM and cfg bit positions for the SDRAM size probe
package sdram_probe_pkg;
  typedef enum logic [2:0] {WAIT_INIT, ISSUE, GUARD, WAIT_RDY, FINISH, CLEAR, DONE} state_t;
  typedef struct packed {
    logic        is_read;
    logic [26:0] addr;
    logic [15:0] data;
    logic [1:0]  cfg_bit;
  } step_t;
  localparam int CFG_DONE = 15;
  localparam int CFG_ERR = 14;
  localparam logic [2:0] LAST_STEP = 3'd6;
  localparam logic [2:0] CLR_STEP = 3'd7;
  localparam step_t STEP_ROM [7] = '{
    '{1'b0, 27'h4000000, 16'd3128, 2'd0},
    '{1'b0, 27'h2000000, 16'd2064, 2'd0},
    '{1'b0, 27'h0000000, 16'd1032, 2'd0},
    '{1'b0, 27'h1000000, 16'd12345, 2'd0},
    '{1'b1, 27'h4000000, 16'd3128, 2'd2},
    '{1'b1, 27'h2000000, 16'd2064, 2'd1},
    '{1'b1, 27'h0000000, 16'd1032, 2'd0}
  };
endpackage

// File: rtl/sdram_size_probe_if.sv
// sdram_size_probe_if: command port between the size probe and the SDRAM controller
interface sdram_size_probe_if;
  logic        sdram_ready;
  logic [15:0] sdram_dout;
  logic [26:0] sdram_addr;
  logic [15:0] sdram_din;
  logic        sdram_we;
  logic        sdram_rd;
  modport master (input sdram_ready, sdram_dout, output sdram_addr, sdram_din, sdram_we, sdram_rd);
  modport slave (output sdram_ready, sdram_dout, input sdram_addr, sdram_din, sdram_we, sdram_rd);
endinterface

// File: rtl/sdram_size_probe.sv
// sdram_size_probe: sizes the SDRAM by alias write/readback, publishes cfg, then zero-fills the detected range
module sdram_size_probe
  import sdram_probe_pkg::*;
#(
  parameter int GUARD_CYCLES = 1,
  parameter int TIMEOUT = 65535,
  parameter int CLEAR_EN = 1
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  sdram_size_probe_if.master         bus,
  output logic [15:0]                cfg,
  output logic                       clear_done
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 2);
  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [GW-1:0] g_q, g_d;
  logic [TW-1:0] t_q, t_d;
  logic [26:0] clr_addr_q, clr_addr_d;
  logic [26:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic        we_q, we_d, rd_q, rd_d;
  logic [15:0] cfg_q, cfg_d;
  logic        clear_done_q, clear_done_d;
  step_t       cur;
  logic [26:0] clr_last;
  logic [TW-1:0] t_inc;
  assign cur = STEP_ROM[step_q == CLR_STEP ? 3'd0 : step_q];
  assign clr_last = cfg_q[2] ? 27'h3FFFFFF : cfg_q[1] ? 27'h1FFFFFF : 27'h0FFFFFF;
  assign t_inc = t_q + TW'(1);
  // Next-state and command generation; pulses default low so each lasts one cycle
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    g_d = g_q;
    t_d = t_q;
    clr_addr_d = clr_addr_q;
    addr_d = addr_q;
    din_d = din_q;
    we_d = 1'b0;
    rd_d = 1'b0;
    cfg_d = cfg_q;
    clear_done_d = clear_done_q;
    case (state_q)
      WAIT_INIT: state_d = bus.sdram_ready ? ISSUE : WAIT_INIT;
      ISSUE: if (bus.sdram_ready) begin
        we_d = ~cur.is_read;
        rd_d = cur.is_read;
        addr_d = cur.addr;
        din_d = cur.data;
        g_d = '0;
        t_d = '0;
        state_d = GUARD_CYCLES == 0 ? WAIT_RDY : GUARD;
      end
      CLEAR: if (bus.sdram_ready) begin
        we_d = 1'b1;
        addr_d = clr_addr_q;
        din_d = 16'h0;
        g_d = '0;
        t_d = '0;
        state_d = GUARD_CYCLES == 0 ? WAIT_RDY : GUARD;
      end
      GUARD: begin
        g_d = g_q + GW'(1);
        state_d = g_q == GW'(GUARD_CYCLES - 1) ? WAIT_RDY : GUARD;
      end
      WAIT_RDY: if (bus.sdram_ready) begin
        if (step_q == CLR_STEP) begin
          clr_addr_d = clr_addr_q == clr_last ? clr_addr_q : clr_addr_q + 27'd1;
          clear_done_d = clr_addr_q == clr_last;
          state_d = clr_addr_q == clr_last ? DONE : CLEAR;
        end else begin
          if (cur.is_read) cfg_d[cur.cfg_bit] = bus.sdram_dout == cur.data;
          if (step_q == LAST_STEP) cfg_d[CFG_DONE] = 1'b1;
          step_d = step_q + 3'd1;
          state_d = step_q == LAST_STEP ? FINISH : ISSUE;
        end
      end else begin
        t_d = t_inc;
        if (t_inc == TW'(TIMEOUT)) begin
          cfg_d[CFG_DONE] = 1'b1;
          cfg_d[CFG_ERR] = 1'b1;
          clear_done_d = 1'b1;
          state_d = DONE;
        end
      end
      FINISH: begin
        state_d = (CLEAR_EN != 0 && |cfg_q[2:0]) ? CLEAR : DONE;
        clear_done_d = !(CLEAR_EN != 0 && |cfg_q[2:0]);
      end
      DONE: state_d = DONE;
      default: state_d = WAIT_INIT;
    endcase
  end
  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= WAIT_INIT;
      step_q <= '0;
      g_q <= '0;
      t_q <= '0;
      clr_addr_q <= '0;
      addr_q <= '0;
      din_q <= '0;
      we_q <= 1'b0;
      rd_q <= 1'b0;
      cfg_q <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      g_q <= g_d;
      t_q <= t_d;
      clr_addr_q <= clr_addr_d;
      addr_q <= addr_d;
      din_q <= din_d;
      we_q <= we_d;
      rd_q <= rd_d;
      cfg_q <= cfg_d;
      clear_done_q <= clear_done_d;
    end
  end
  assign bus.sdram_addr = addr_q;
  assign bus.sdram_din = din_q;
  assign bus.sdram_we = we_q;
  assign bus.sdram_rd = rd_q;
  assign cfg = cfg_q;
  assign clear_done = clear_done_q;
endmodule

// File: tb/tb_sdram_size_probe.sv
// tb_sdram_size_probe: SDRAM sizing scenarios against a memory/alias model and an expected-command scoreboard
module tb_sdram_size_probe;
  import sdram_probe_pkg::*;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic [15:0] cfg;
  logic clear_done;
  always #5 clk_sys = ~clk_sys;
  sdram_size_probe_if bus();
  sdram_size_probe #(.GUARD_CYCLES(1), .TIMEOUT(100), .CLEAR_EN(1)) dut (
    .clk_sys(clk_sys), .reset(reset), .bus(bus), .cfg(cfg), .clear_done(clear_done)
  );
  int total = 0;
  int bad = 0;
  logic [26:0] mask = 27'h7FFFFFF;
  bit present = 1'b1;
  bit stall = 1'b0;
  logic [15:0] exp_cfg_v = 16'h0;
  logic [26:0] jump_to = '0;
  int jump_gen = 0;
  logic [26:0] pa [7] = '{27'h4000000, 27'h2000000, 27'h0, 27'h1000000, 27'h4000000, 27'h2000000, 27'h0};
  logic [15:0] pd [7] = '{16'd3128, 16'd2064, 16'd1032, 16'd12345, 16'd3128, 16'd2064, 16'd1032};
  bit prd [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic logic [15:0] exp_cfg(input logic [26:0] m, input bit pres);
    logic [26:0] wa [4];
    logic [15:0] wd [4];
    logic [15:0] got;
    logic [15:0] r;
    wa = '{27'h4000000, 27'h2000000, 27'h0, 27'h1000000};
    wd = '{16'd3128, 16'd2064, 16'd1032, 16'd12345};
    r = 16'h8000;
    for (int k = 0; k < 3; k++) begin
      got = pres ? 16'h0 : 16'hFFFF;
      for (int j = 0; j < 4; j++) if (pres && (wa[j] & m) == (wa[k] & m)) got = wd[j];
      r[2-k] = got == wd[k];
    end
    return r;
  endfunction
  logic [15:0] mem [logic [26:0]];
  int busy = 0;
  bit stuck = 1'b0;
  always @(negedge clk_sys) begin
    if (reset) begin
      busy = 0;
      stuck = 1'b0;
      bus.sdram_ready = 1'b1;
      bus.sdram_dout = 16'h0;
      mem.delete();
    end else if (bus.sdram_we || bus.sdram_rd) begin
      if (bus.sdram_we) begin
        if (present) mem[bus.sdram_addr & mask] = bus.sdram_din;
        if (stall && bus.sdram_addr == 27'h0 && bus.sdram_din == 16'd1032) stuck = 1'b1;
      end else begin
        bus.sdram_dout = !present ? 16'hFFFF : mem.exists(bus.sdram_addr & mask) ? mem[bus.sdram_addr & mask] : 16'h0;
      end
      busy = 3;
      bus.sdram_ready = 1'b0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0 && !stuck) bus.sdram_ready = 1'b1;
    end
  end
  logic rdy_at_edge = 1'b0;
  always @(posedge clk_sys) rdy_at_edge <= bus.sdram_ready;
  int cyc = 0;
  int exp_i = 0;
  logic [26:0] clr_next = '0;
  logic [26:0] clr_last_a = '0;
  int clr_writes = 0;
  int jump_seen = 0;
  int t_w2 = -1, t_fin = -1, t_cd = -1;
  logic prev_we = 1'b0, prev_rd = 1'b0, done_prev = 1'b0;
  always @(negedge clk_sys) begin
    cyc++;
    if (reset) begin
      exp_i = 0;
      clr_next = '0;
      clr_writes = 0;
      clr_last_a = '0;
      t_w2 = -1;
      t_fin = -1;
      t_cd = -1;
      prev_we = 1'b0;
      prev_rd = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (jump_gen != jump_seen) begin
        jump_seen = jump_gen;
        clr_next = jump_to;
      end
      if (bus.sdram_we || bus.sdram_rd) begin
        check("we_and_rd", {63'd0, bus.sdram_we & bus.sdram_rd}, 64'd0);
        check("pulse_len", {63'd0, (prev_we & bus.sdram_we) | (prev_rd & bus.sdram_rd)}, 64'd0);
        check("cmd_without_ready", {63'd0, rdy_at_edge}, 64'd1);
        check("cmd_after_done", {63'd0, done_prev}, 64'd0);
        if (exp_i < 7) begin
          check("probe_cmd", {bus.sdram_rd, bus.sdram_we, bus.sdram_addr, bus.sdram_we ? bus.sdram_din : 16'h0},
                {prd[exp_i], !prd[exp_i], pa[exp_i], prd[exp_i] ? 16'h0 : pd[exp_i]});
          if (exp_i == 2) t_w2 = cyc;
          exp_i++;
        end else begin
          check("clear_cmd", {bus.sdram_rd, bus.sdram_we, bus.sdram_addr, bus.sdram_din}, {1'b0, 1'b1, clr_next, 16'h0});
          clr_last_a = bus.sdram_addr;
          clr_next = clr_next + 27'd1;
          clr_writes++;
        end
      end
      if (cfg[15]) check("cfg", {48'd0, cfg}, {48'd0, exp_cfg_v});
      else check("cfg_before_finish", {51'd0, cfg[15:3]}, 64'd0);
      if (clear_done) check("clear_done_implies_cfg15", {63'd0, cfg[15]}, 64'd1);
      if (cfg[15] && t_fin < 0) t_fin = cyc;
      if (clear_done && t_cd < 0) t_cd = cyc;
      prev_we = bus.sdram_we;
      prev_rd = bus.sdram_rd;
      done_prev = clear_done;
    end
  end
  task automatic run(input int md, input bit stl, input bit rmid, input logic [15:0] lit, input int nclr, input logic [26:0] last);
    int n;
    mask = md == 1 ? 27'h1FFFFFF : 27'h7FFFFFF;
    present = md != 2;
    stall = stl;
    exp_cfg_v = stl ? 16'hC000 : exp_cfg(md == 1 ? 27'h1FFFFFF : 27'h7FFFFFF, md != 2);
    reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    #2;
    check("rst_cfg", {48'd0, cfg}, 64'd0);
    check("rst_outputs", {clear_done, bus.sdram_we, bus.sdram_rd, bus.sdram_addr, bus.sdram_din}, 64'd0);
    check("rst_state", 64'(dut.state_q), 64'(WAIT_INIT));
    reset = 1'b0;
    if (rmid) begin
      n = 0;
      while (exp_i < 6 && n < 500) begin @(posedge clk_sys); n++; end
      #2 reset = 1'b1;
      @(posedge clk_sys);
      #2;
      check("mid_reach_step5", {63'd0, n < 500}, 64'd1);
      check("mid_cfg", {48'd0, cfg}, 64'd0);
      check("mid_cmd", {62'd0, bus.sdram_we, bus.sdram_rd}, 64'd0);
      check("mid_state", 64'(dut.state_q), 64'(WAIT_INIT));
      reset = 1'b0;
    end
    if (nclr > 0) begin
      n = 0;
      while (clr_next < 27'd3 && n < 2000) begin @(posedge clk_sys); n++; end
      #2;
      check("clear_start", {37'd0, clr_next}, 64'd3);
      force dut.clr_addr_q = last - 27'd4;
      jump_to = last - 27'd3;
      jump_gen++;
      #1 release dut.clr_addr_q;
    end
    n = 0;
    while (!clear_done && n < 3000) begin @(posedge clk_sys); n++; end
    #2;
    check("clear_done", {63'd0, clear_done}, 64'd1);
    check("cfg_final", {48'd0, cfg}, {48'd0, lit});
    check("probe_cmds", 64'(exp_i), stl ? 64'd3 : 64'd7);
    check("clear_writes", 64'(clr_writes), 64'(nclr));
    if (nclr > 0) check("clear_last_addr", {37'd0, clr_last_a}, {37'd0, last});
    if (stl) check("timeout_latency", 64'(t_fin - t_w2), 64'd101);
    if (md == 2) check("skip_clear_gap", 64'(t_cd - t_fin), 64'd1);
    repeat (10) @(posedge clk_sys);
  endtask
  initial begin
    run(0, 1'b0, 1'b0, 16'h8007, 7, 27'h3FFFFFF);
    run(1, 1'b0, 1'b0, 16'h8001, 7, 27'h0FFFFFF);
    run(2, 1'b0, 1'b0, 16'h8000, 0, 27'h0);
    run(0, 1'b1, 1'b0, 16'hC000, 0, 27'h0);
    run(0, 1'b0, 1'b1, 16'h8007, 7, 27'h3FFFFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
